// File: rtl/chaser_index_gen_if.sv
// chaser_index_gen_if -- control/status bundle of the LED chaser index generator.
//   en       : free-run enable (1 = prescaler stepping, 0 = button stepping)
//   dir      : step direction (0 = up, 1 = down)
//   pp       : ping-pong request (used only when CHASER_PINGPONG_EN is defined)
//   step_btn : raw asynchronous push-button, active-high
//   idx      : registered 3-bit position for the 3-to-8 decoder
//   tick     : one-cycle pulse in the first cycle a new idx is visible
//   wrap     : one-cycle pulse with tick on 7->0, 0->7 or a ping-pong reversal
// master drives the controls, slave (the generator) drives idx/tick/wrap.
interface chaser_index_gen_if;
   logic       en;
   logic       dir;
   logic       pp;
   logic       step_btn;
   logic [2:0] idx;
   logic       tick;
   logic       wrap;

   modport master (output en, dir, pp, step_btn, input idx, tick, wrap);
   modport slave  (input en, dir, pp, step_btn, output idx, tick, wrap);
endinterface

// File: rtl/chaser_index_gen.sv
// chaser_index_gen -- 3-bit position generator for an 8-LED chaser.
// Steps every DIV cycles while en=1, or once per debounced button press while
// en=0. Optional ping-pong bouncing is built only when the macro
// CHASER_PINGPONG_EN is defined; otherwise pp is ignored and stepping is mod-8.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   ch_io : chaser_index_gen_if.slave (en, dir, pp, step_btn -> idx, tick, wrap)
// Parameters:
//   DIV       : clk cycles per automatic step (>= 2)
//   DB_CYCLES : stable synchronized samples needed to accept a button level (>= 1)
module chaser_index_gen #(
   parameter int unsigned DIV       = 50_000_000,
   parameter int unsigned DB_CYCLES = 1_000_000
) (
   input  logic               clk,
   input  logic               rst_n,
   chaser_index_gen_if.slave  ch_io
);
   localparam int PW = $clog2(DIV);
   localparam int DW = $clog2(DB_CYCLES + 1);

   logic [PW-1:0] pre_q, pre_d;
   logic          adv;
   logic [1:0]    sync_q;
   logic [DW-1:0] dbc_q, dbc_d;
   logic          db_q, db_d, db_prev_q;
   logic          btn_req;
   logic          step;
   logic [2:0]    idx_q, idx_d;
   logic          tick_q, tick_d;
   logic          wrap_q, wrap_d;

`ifdef CHASER_PINGPONG_EN
   logic          pp_prev_q;
   logic          ppdir_q, ppdir_d;
   logic          ppdir_eff;
`else
   logic          unused_pp;
   assign unused_pp = ch_io.pp;
`endif

   // Prescaler: held at 0 while disabled so re-enabling gives a full period.
   always_comb begin
      pre_d = '0;
      adv   = 1'b0;
      if (ch_io.en) begin
         if (pre_q == PW'(DIV - 1)) adv = 1'b1;
         else                       pre_d = pre_q + 1'b1;
      end
   end

   // Debounce: count consecutive disagreeing samples; any agreement clears.
   always_comb begin
      dbc_d = '0;
      db_d  = db_q;
      if (sync_q[1] != db_q) begin
         if (dbc_q == DW'(DB_CYCLES - 1)) db_d  = ~db_q;
         else                            dbc_d = dbc_q + 1'b1;
      end
   end

   assign btn_req = db_q & ~db_prev_q;
   // Button requests are simply dropped while free-running.
   assign step    = ch_io.en ? adv : btn_req;

   always_comb begin
      idx_d  = idx_q;
      tick_d = step;
      wrap_d = 1'b0;
`ifdef CHASER_PINGPONG_EN
      // A rising pp loads the bounce direction from dir in that same cycle.
      ppdir_eff = (ch_io.pp && !pp_prev_q) ? ch_io.dir : ppdir_q;
      ppdir_d   = ppdir_eff;
      if (step && ch_io.pp) begin
         if (!ppdir_eff) begin
            if (idx_q == 3'd7) begin
               idx_d   = 3'd6;
               wrap_d  = 1'b1;
               ppdir_d = 1'b1;
            end else begin
               idx_d = idx_q + 3'd1;
            end
         end else begin
            if (idx_q == 3'd0) begin
               idx_d   = 3'd1;
               wrap_d  = 1'b1;
               ppdir_d = 1'b0;
            end else begin
               idx_d = idx_q - 3'd1;
            end
         end
      end else
`endif
      if (step) begin
         if (!ch_io.dir) begin
            idx_d  = idx_q + 3'd1;
            wrap_d = (idx_q == 3'd7);
         end else begin
            idx_d  = idx_q - 3'd1;
            wrap_d = (idx_q == 3'd0);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q     <= '0;
         sync_q    <= '0;
         dbc_q     <= '0;
         db_q      <= 1'b0;
         db_prev_q <= 1'b0;
         idx_q     <= '0;
         tick_q    <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         pre_q     <= pre_d;
         sync_q    <= {sync_q[0], ch_io.step_btn};
         dbc_q     <= dbc_d;
         db_q      <= db_d;
         db_prev_q <= db_q;
         idx_q     <= idx_d;
         tick_q    <= tick_d;
         wrap_q    <= wrap_d;
      end
   end

`ifdef CHASER_PINGPONG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pp_prev_q <= 1'b0;
         ppdir_q   <= 1'b0;
      end else begin
         pp_prev_q <= ch_io.pp;
         ppdir_q   <= ppdir_d;
      end
   end
`endif

   assign ch_io.idx  = idx_q;
   assign ch_io.tick = tick_q;
   assign ch_io.wrap = wrap_q;
endmodule

// File: tb/tb_chaser_index_gen.sv
module tb_chaser_index_gen;
   localparam int DIV = 4;
   localparam int DB  = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   chaser_index_gen_if bus ();
   chaser_index_gen #(.DIV(DIV), .DB_CYCLES(DB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ch_io (bus)
   );

   typedef struct {
      int idx;
      bit wrap;
      int edge_n;
   } exp_t;

   exp_t q[$];
   int   pend[$];      // edges at which an accepted press must show its step
   int   edges = 0;
   int   total = 0;
   int   bad   = 0;
   int   m_idx = 0;    // reference position
   int   r     = 0;    // consecutive enabled edges
   bit   m_ppd = 0;
   bit   m_ppp = 0;
   int   last_e;

   always @(posedge clk) edges++;

   // Reference step rules: one step per DIV enabled edges, or at a scheduled
   // press edge when disabled; position arithmetic done on plain integers.
   task automatic model_edge(input bit e, input bit d, input bit p, input int n);
      bit stp, w, de;
      de = m_ppd;
      if (p && !m_ppp) de = d;
      if (e) begin
         r++;
         stp = (r % DIV == 0);
      end else begin
         r   = 0;
         stp = (pend.size() > 0 && pend[0] == n);
      end
      if (pend.size() > 0 && pend[0] <= n) void'(pend.pop_front());
      if (stp) begin
         w = 0;
`ifdef CHASER_PINGPONG_EN
         if (p) begin
            if (!de) begin
               if (m_idx == 7) begin m_idx = 6; w = 1; de = 1; end
               else m_idx++;
            end else begin
               if (m_idx == 0) begin m_idx = 1; w = 1; de = 0; end
               else m_idx--;
            end
         end else
`endif
         begin
            if (!d) begin w = (m_idx == 7); m_idx = (m_idx + 1) % 8; end
            else    begin w = (m_idx == 0); m_idx = (m_idx + 7) % 8; end
         end
         q.push_back('{m_idx, w, n});
      end
      m_ppd = de;
      m_ppp = p;
   endtask

   task automatic cyc(input bit e, input bit b, input bit d, input bit p);
      @(posedge clk); #1;
      bus.en = e; bus.step_btn = b; bus.dir = d; bus.pp = p;
      last_e = edges;
      model_edge(e, d, p, edges + 1);
   endtask

   task automatic press(input int len, input int gap);
      cyc(0, 1, 1'($urandom % 2), 0);
      if (len >= DB) pend.push_back(last_e + DB + 3);
      repeat (len - 1) cyc(0, 1, 1'($urandom % 2), 0);
      repeat (gap) cyc(0, 0, 1'($urandom % 2), 0);
   endtask

   task automatic chk(input string nm, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, req);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("rst_idx",  int'(bus.idx),  0);
      chk("rst_tick", int'(bus.tick), 0);
      chk("rst_wrap", int'(bus.wrap), 0);
      q.delete(); pend.delete();
      m_idx = 0; r = 0; m_ppd = 0; m_ppp = 0;
      @(posedge clk); #1;
      bus.en = 0; bus.step_btn = 0; bus.pp = 0; bus.dir = 0;
      rst_n = 1'b1;
   endtask

   // Monitor: every tick must match the oldest expected step, cycle-exact.
   int   prev_idx = 0;
   bit   prev_tick = 0;
   exp_t ce;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_idx  = 0;
         prev_tick = 0;
      end else begin
         if (q.size() > 0 && q[0].edge_n < edges) begin
            total++; bad++;
            $display("FAIL missing_tick: no tick at edge %0d, expected idx=%0d", q[0].edge_n, q[0].idx);
            void'(q.pop_front());
         end
         total++;
         if (bus.tick) begin
            if (q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_tick: edge %0d idx=%0d", edges, bus.idx);
            end else begin
               ce = q.pop_front();
               if (bus.idx !== 3'(ce.idx) || bus.wrap !== ce.wrap || edges != ce.edge_n) begin
                  bad++;
                  $display("FAIL step: got idx=%0d wrap=%0b edge=%0d expected idx=%0d wrap=%0b edge=%0d",
                           bus.idx, bus.wrap, edges, ce.idx, ce.wrap, ce.edge_n);
               end
            end
            if (prev_tick) begin
               bad++;
               $display("FAIL tick_twice: edge %0d got 1 expected 0", edges);
            end
         end else if (bus.idx !== 3'(prev_idx) || bus.wrap !== 1'b0) begin
            bad++;
            $display("FAIL idle_change: got idx=%0d wrap=%0b expected idx=%0d wrap=0",
                     bus.idx, bus.wrap, prev_idx);
         end
         prev_idx  = int'(bus.idx);
         prev_tick = bus.tick;
      end
   end

   initial begin
      bus.en = 0; bus.dir = 0; bus.pp = 0; bus.step_btn = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("init_idx",  int'(bus.idx),  0);
      chk("init_tick", int'(bus.tick), 0);
      chk("init_wrap", int'(bus.wrap), 0);
      rst_n = 1'b1;

      // Free-run up: 1..7,0 with a wrap at 7->0.
      repeat (8 * DIV) cyc(1, 0, 0, 0);
      repeat (3) cyc(0, 0, 0, 0);

      // Free-run down from reset: 7 with wrap, then 6, 5.
      do_reset();
      repeat (3 * DIV) cyc(1, 0, 1, 0);
      repeat (3) cyc(0, 0, 0, 0);

      // Button stepping: clean press, short glitch, long hold, random presses.
      press(10, 10);
      press(2, 10);
      press(50, 10);
      repeat (12) press(int'($urandom_range(1, 6)), int'($urandom_range(DB + 3, DB + 8)));

      // Button pressed while free-running must not add steps.
      repeat (20) cyc(1, 1, 1'($urandom % 2), 0);
      repeat (15) cyc(1, 0, 1'($urandom % 2), 0);
      // Random enable gating with random direction.
      repeat (100) cyc(($urandom % 6) != 0, 0, 1'($urandom % 2), 0);
      repeat (10) cyc(0, 0, 0, 0);

`ifdef CHASER_PINGPONG_EN
      do_reset();
      repeat (15 * DIV) cyc(1, 0, 0, 1);
      repeat (200) cyc(($urandom % 4) != 0, 0, 1'($urandom % 2), ($urandom % 8) != 0);
      repeat (5) cyc(0, 0, 0, 0);
`endif

      // Reset in mid-count at idx=5, then a full DIV before the first step.
      do_reset();
      for (int k = 0; k < 100 && !(m_idx == 5 && r % DIV == 2); k++) cyc(1, 0, 0, 0);
      chk("reach_idx5", int'(bus.idx), 5);
      do_reset();
      repeat (3 * DIV) cyc(1, 0, 0, 0);

      repeat (10) cyc(0, 0, 0, 0);
      chk("queue_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
